// File: rtl/shifter_pkg.sv
// Shared mode encodings and helpers for the pipelined barrel shifter.
// Pure definitions: no latency and no flow control of their own.
package shifter_pkg;

    localparam logic [2:0] MODE_SLL = 3'b000;
    localparam logic [2:0] MODE_SRL = 3'b001;
    localparam logic [2:0] MODE_SRA = 3'b010;
    localparam logic [2:0] MODE_ROL = 3'b011;
    localparam logic [2:0] MODE_ROR = 3'b100;

    typedef enum logic [1:0] {
        FILL_ZERO,
        FILL_SIGN,
        FILL_WRAP
    } fill_e;

    // Widest operand bit_reverse can handle; callers zero-extend into it.
    localparam int REV_MAX_W = 256;

    function automatic logic is_right(input logic [2:0] mode);
        return (mode == MODE_SRL) || (mode == MODE_SRA) || (mode == MODE_ROR);
    endfunction

    function automatic logic is_reserved(input logic [2:0] mode);
        return mode > MODE_ROR;
    endfunction

    function automatic fill_e fill_of(input logic [2:0] mode);
        fill_e f;
        case (mode)
            MODE_SRA: f = FILL_SIGN;
            MODE_ROL: f = FILL_WRAP;
            MODE_ROR: f = FILL_WRAP;
            default:  f = FILL_ZERO;
        endcase
        return f;
    endfunction

    // Reverses the low w bits of v; bits at and above w come back as zero.
    function automatic logic [REV_MAX_W-1:0] bit_reverse(input logic [REV_MAX_W-1:0] v,
                                                         input int w);
        logic [REV_MAX_W-1:0] r;
        r = '0;
        for (int i = 0; i < REV_MAX_W; i++) begin
            if (i < w) begin
                r[i] = v[w-1-i];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/shift_level.sv
// One 2^K left-shift mux level with mode-selected fill, followed by its stage register.
// Latency 1 cycle; holds its contents while downstream stalls, ready = !valid || downstream ready.
module shift_level
    import shifter_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int K     = 0,
    parameter int AMT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             vld_i,
    output logic             rdy_o,
    input  logic [WIDTH-1:0] dat_i,
    input  logic [AMT_W-1:0] amt_i,
    input  logic [2:0]       mode_i,
    input  logic             sign_i,
    output logic             vld_o,
    input  logic             rdy_i,
    output logic [WIDTH-1:0] dat_o,
    output logic [AMT_W-1:0] amt_o,
    output logic [2:0]       mode_o,
    output logic             sign_o
);

    localparam int S = 1 << K;

    logic             vld_q;
    logic [WIDTH-1:0] dat_q;
    logic [WIDTH-1:0] dat_d;
    logic [AMT_W-1:0] amt_q;
    logic [2:0]       mode_q;
    logic             sign_q;
    logic [S-1:0]     fill;

    always_comb begin
        fill = '0;
        case (fill_of(mode_i))
            FILL_SIGN: fill = {S{sign_i}};
            FILL_WRAP: fill = dat_i[WIDTH-1 -: S];
            default:   fill = '0;
        endcase
        dat_d = dat_i;
        if (amt_i[K]) begin
            dat_d = {dat_i[WIDTH-S-1:0], fill};
        end
    end

    // An empty stage always accepts, so bubbles are squeezed out under stall.
    assign rdy_o = !vld_q || rdy_i;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q  <= 1'b0;
            dat_q  <= '0;
            amt_q  <= '0;
            mode_q <= '0;
            sign_q <= 1'b0;
        end else if (rdy_o) begin
            vld_q <= vld_i;
            if (vld_i) begin
                dat_q  <= dat_d;
                amt_q  <= amt_i;
                mode_q <= mode_i;
                sign_q <= sign_i;
            end
        end
    end

    assign vld_o  = vld_q;
    assign dat_o  = dat_q;
    assign amt_o  = amt_q;
    assign mode_o = mode_q;
    assign sign_o = sign_q;

endmodule

// File: rtl/pipelined_barrel_shifter.sv
// Pipelined SLL/SRL/SRA/ROL/ROR shifter: log2(WIDTH) registered left-shift levels, right modes via bit reversal.
// Latency log2(WIDTH) cycles at 1 beat/cycle; valid/ready backpressure ripples combinationally out_ready -> in_ready.
module pipelined_barrel_shifter
    import shifter_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH-1:0]         in_data,
    input  logic [$clog2(WIDTH)-1:0] in_amt,
    input  logic [2:0]               in_mode,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         out_data
);

    localparam int AMT_W  = $clog2(WIDTH);
    localparam int LEVELS = AMT_W;

    // Index 0 is the entry point; index k+1 is the register after level k.
    logic             vld_s  [LEVELS+1];
    logic             rdy_s  [LEVELS+1];
    logic [WIDTH-1:0] dat_s  [LEVELS+1];
    logic [AMT_W-1:0] amt_s  [LEVELS+1];
    logic [2:0]       mode_s [LEVELS+1];
    logic             sign_s [LEVELS+1];

    function automatic logic [WIDTH-1:0] rev(input logic [WIDTH-1:0] x);
        return WIDTH'(bit_reverse(REV_MAX_W'(x), WIDTH));
    endfunction

    // Reserved modes ride through with a zero amount so every level is a pass-through.
    assign vld_s[0]  = in_valid;
    assign dat_s[0]  = is_right(in_mode) ? rev(in_data) : in_data;
    assign amt_s[0]  = is_reserved(in_mode) ? '0 : in_amt;
    assign mode_s[0] = in_mode;
    assign sign_s[0] = in_data[WIDTH-1];
    assign in_ready  = rdy_s[0];

    for (genvar k = 0; k < LEVELS; k++) begin : g_level
        shift_level #(
            .WIDTH (WIDTH),
            .K     (k),
            .AMT_W (AMT_W)
        ) u_level (
            .clk    (clk),
            .rst    (rst),
            .vld_i  (vld_s[k]),
            .rdy_o  (rdy_s[k]),
            .dat_i  (dat_s[k]),
            .amt_i  (amt_s[k]),
            .mode_i (mode_s[k]),
            .sign_i (sign_s[k]),
            .vld_o  (vld_s[k+1]),
            .rdy_i  (rdy_s[k+1]),
            .dat_o  (dat_s[k+1]),
            .amt_o  (amt_s[k+1]),
            .mode_o (mode_s[k+1]),
            .sign_o (sign_s[k+1])
        );
    end

    assign rdy_s[LEVELS] = out_ready;
    assign out_valid     = vld_s[LEVELS];
    assign out_data      = is_right(mode_s[LEVELS]) ? rev(dat_s[LEVELS]) : dat_s[LEVELS];

endmodule

// File: tb/tb_pipelined_barrel_shifter.sv
// Scoreboard bench for pipelined_barrel_shifter at WIDTH=8 and WIDTH=32.
module tb_pipelined_barrel_shifter;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] d;
        int          acc;
        bit          lat;
    } exp_t;

    exp_t q8[$];
    exp_t q32[$];

    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  in_data = '0;
    logic [2:0]  in_amt = '0;
    logic [2:0]  in_mode = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [7:0]  out_data;

    logic        w_in_valid = 1'b0;
    logic        w_in_ready;
    logic [31:0] w_in_data = '0;
    logic [4:0]  w_in_amt = '0;
    logic [2:0]  w_in_mode = '0;
    logic        w_out_valid;
    logic        w_out_ready = 1'b1;
    logic [31:0] w_out_data;

    pipelined_barrel_shifter #(.WIDTH(8)) u_dut8 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_amt    (in_amt),
        .in_mode   (in_mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

    pipelined_barrel_shifter #(.WIDTH(32)) u_dut32 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (w_in_valid),
        .in_ready  (w_in_ready),
        .in_data   (w_in_data),
        .in_amt    (w_in_amt),
        .in_mode   (w_in_mode),
        .out_valid (w_out_valid),
        .out_ready (w_out_ready),
        .out_data  (w_out_data)
    );

    // Reference: plain arithmetic on a w-bit value.
    function automatic logic [31:0] model(input logic [31:0] d, input int a,
                                          input logic [2:0] m, input int w);
        longint unsigned mask;
        longint unsigned x;
        longint unsigned r;
        mask = (64'd1 << w) - 1;
        x = {32'd0, d} & mask;
        case (m)
            3'd0: r = x << a;
            3'd1: r = x >> a;
            3'd2: begin
                r = x >> a;
                if (((x >> (w - 1)) & 1) == 1) r = r | (mask & ~(mask >> a));
            end
            3'd3: r = (x << a) | (x >> (w - a));
            3'd4: r = (x >> a) | (x << (w - a));
            default: r = x;
        endcase
        return 32'(r & mask);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic send8(input logic [7:0] d, input int a, input logic [2:0] m,
                         input logic [7:0] e, input bit lat);
        bit ok;
        ok = 1'b0;
        in_valid = 1'b1;
        in_data  = d;
        in_amt   = 3'(a);
        in_mode  = m;
        for (int t = 0; t < 300 && !ok; t++) begin
            @(negedge clk);
            if (in_ready) begin
                q8.push_back('{d: {24'd0, e}, acc: cyc, lat: lat});
                ok = 1'b1;
            end else begin
                @(posedge clk);
            end
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL send8_timeout actual=not_accepted required=accepted");
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_data  = 8'($urandom);
    endtask

    task automatic send32(input logic [31:0] d, input int a, input logic [2:0] m,
                          input logic [31:0] e, input bit lat);
        bit ok;
        ok = 1'b0;
        w_in_valid = 1'b1;
        w_in_data  = d;
        w_in_amt   = 5'(a);
        w_in_mode  = m;
        for (int t = 0; t < 300 && !ok; t++) begin
            @(negedge clk);
            if (w_in_ready) begin
                q32.push_back('{d: e, acc: cyc, lat: lat});
                ok = 1'b1;
            end else begin
                @(posedge clk);
            end
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL send32_timeout actual=not_accepted required=accepted");
        end
        @(posedge clk);
        #1;
        w_in_valid = 1'b0;
    endtask

    task automatic drain(input bit wide);
        for (int t = 0; t < 600 && (wide ? q32.size() : q8.size()) > 0; t++) @(posedge clk);
        #1;
        check(wide ? "drain32_empty" : "drain8_empty", wide ? q32.size() : q8.size(), 0);
    endtask

    // 0: out_ready held high, 1: held low, 2: random each cycle.
    int or_ctl = 0;
    always @(posedge clk) begin
        #1;
        case (or_ctl)
            1:       out_ready = 1'b0;
            2:       out_ready = 1'($urandom_range(0, 1));
            default: out_ready = 1'b1;
        endcase
    end

    bit         saw_full = 1'b0;
    bit         stalled = 1'b0;
    logic [7:0] held = '0;
    exp_t       e8;
    exp_t       e32;

    always @(negedge clk) begin
        if (rst) begin
            stalled = 1'b0;
        end else begin
            if (stalled) begin
                check("stall_valid", 32'(out_valid), 32'd1);
                check("stall_data", 32'(out_data), 32'(held));
            end
            if (out_ready) check("in_ready_when_out_ready", 32'(in_ready), 32'd1);
            if (!in_ready) saw_full = 1'b1;
            if (out_valid && out_ready) begin
                if (q8.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL spurious8 actual=%0h required=no_beat", out_data);
                end else begin
                    e8 = q8.pop_front();
                    check("data8", 32'(out_data), e8.d);
                    if (e8.lat) check("latency8", 32'(cyc - e8.acc), 32'd3);
                end
            end
            stalled = out_valid && !out_ready;
            held    = out_data;
        end
    end

    always @(negedge clk) begin
        if (!rst && w_out_valid && w_out_ready) begin
            if (q32.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL spurious32 actual=%0h required=no_beat", w_out_data);
            end else begin
                e32 = q32.pop_front();
                check("data32", w_out_data, e32.d);
                if (e32.lat) check("latency32", 32'(cyc - e32.acc), 32'd5);
            end
        end
    end

    logic [7:0]  rd;
    int          ra;
    logic [2:0]  rm;
    logic [31:0] wd;
    logic [7:0]  exp_mode [5];

    initial begin
        exp_mode = '{8'hB0, 8'h12, 8'hF2, 8'hB4, 8'hD2};

        // Reset state while rst is held.
        #2;
        check("rst_out_valid8", 32'(out_valid), 32'd0);
        check("rst_out_data8", 32'(out_data), 32'd0);
        check("rst_out_valid32", 32'(w_out_valid), 32'd0);
        check("rst_out_data32", w_out_data, 32'd0);
        repeat (2) @(posedge clk);
        #3 rst = 1'b0;
        #1;
        check("in_ready_after_rst8", 32'(in_ready), 32'd1);
        check("in_ready_after_rst32", 32'(w_in_ready), 32'd1);
        @(posedge clk);
        #1;

        // All five modes on 0x96 by 3, then amount-zero and reserved modes.
        for (int m = 0; m < 5; m++) send8(8'h96, 3, 3'(m), exp_mode[m], 1'b1);
        for (int m = 0; m < 5; m++) send8(8'h5A, 0, 3'(m), 8'h5A, 1'b1);
        for (int m = 5; m < 8; m++) send8(8'h5A, 5, 3'(m), 8'h5A, 1'b1);
        drain(1'b0);

        // Back-to-back stream with a 5-cycle output stall in the middle.
        saw_full = 1'b0;
        fork
            begin
                for (int i = 0; i < 16; i++) begin
                    rd = 8'($urandom);
                    ra = $urandom_range(0, 7);
                    rm = 3'($urandom_range(0, 4));
                    send8(rd, ra, rm, 8'(model(32'(rd), ra, rm, 8)), 1'b0);
                end
            end
            begin
                repeat (6) @(posedge clk);
                or_ctl = 1;
                repeat (5) @(posedge clk);
                or_ctl = 0;
            end
        join
        drain(1'b0);
        check("in_ready_dropped_when_full", 32'(saw_full), 32'd1);

        // Random valid and random out_ready over 1000 beats, reserved modes included.
        or_ctl = 2;
        for (int i = 0; i < 1000; i++) begin
            if ($urandom_range(0, 1) == 1) begin
                @(posedge clk);
                #1;
            end
            rd = 8'($urandom);
            ra = $urandom_range(0, 7);
            rm = 3'($urandom_range(0, 7));
            send8(rd, ra, rm, 8'(model(32'(rd), ra, rm, 8)), 1'b0);
        end
        drain(1'b0);
        or_ctl = 0;
        @(posedge clk);
        #1;

        // Asynchronous reset with two beats in flight, one already presented at the output.
        send8(8'hC3, 1, 3'd0, 8'h86, 1'b1);
        send8(8'h3C, 2, 3'd1, 8'h0F, 1'b1);
        @(posedge clk);
        #2;
        check("pre_rst_out_valid", 32'(out_valid), 32'd1);
        rst = 1'b1;
        q8.delete();
        #1;
        check("async_rst_out_valid", 32'(out_valid), 32'd0);
        check("async_rst_out_data", 32'(out_data), 32'd0);
        repeat (2) @(posedge clk);
        #4 rst = 1'b0;
        #1;
        check("in_ready_after_async_rst", 32'(in_ready), 32'd1);
        repeat (10) @(posedge clk);
        #1;
        send8(8'h81, 7, 3'd3, 8'hC0, 1'b1);
        send8(8'h81, 7, 3'd2, 8'hFF, 1'b1);
        drain(1'b0);

        // Wide instance: corner shifts and a few random beats.
        send32(32'h8000_0001, 31, 3'd2, 32'hFFFF_FFFF, 1'b1);
        send32(32'h0000_0001, 1, 3'd4, 32'h8000_0000, 1'b1);
        send32(32'h1234_5678, 0, 3'd3, 32'h1234_5678, 1'b1);
        for (int i = 0; i < 20; i++) begin
            wd = $urandom;
            ra = $urandom_range(0, 31);
            rm = 3'($urandom_range(0, 7));
            send32(wd, ra, rm, model(wd, ra, rm, 32), 1'b1);
        end
        drain(1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipelined_barrel_shifter.md
Name: pipelined_barrel_shifter

Overview:
Parametrised, pipelined successor to the 8-bit combinational left/right barrel shifter. Supports logical left, logical right, arithmetic right, rotate left and rotate right on a WIDTH-bit operand. Built as log2(WIDTH) mux levels, each followed by a pipeline register. Valid/ready handshakes on both sides let it sit in a streaming datapath with back-pressure.

Parameters:
WIDTH, 8, operand width; power of two, >= 2
AMT_W, $clog2(WIDTH), derived localparam (not overridable); width of the shift amount
LEVELS, AMT_W, derived localparam; number of mux levels and pipeline stages (the latency)

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-high
in_valid  in  1  input beat valid
in_ready  out  1  shifter can accept an input beat this cycle
in_data  in  WIDTH  operand
in_amt  in  AMT_W  shift amount, 0..WIDTH-1
in_mode  in  3  operation select (see Behaviour)
out_valid  out  1  result beat valid
out_ready  in  1  downstream accepts the result
out_data  out  WIDTH  result

Behaviour:
- Modes:
  - 000 SLL: zero fill.
  - 001 SRL: zero fill.
  - 010 SRA: fill with in_data[WIDTH-1].
  - 011 ROL.
  - 100 ROR.
  - 101..111 are reserved: data passes through unchanged, whatever in_amt is.
- Core: right-direction modes bit-reverse the operand on entry and bit-reverse the result on exit, so the core only shifts left.
- Level k (k = 0..LEVELS-1) shifts by 2^k when amt[k]=1. Fill source per mode:
  - SLL/SRL: zeros.
  - SRA: the latched sign bit.
  - ROL/ROR: the bits shifted out (wrap-around).
- Each stage register holds: valid, data, remaining amt bits, mode, sign bit.
- Latency: an accepted beat reaches out_data/out_valid exactly LEVELS cycles after acceptance when there is no back-pressure (3 cycles at WIDTH=8). Throughput is 1 beat/cycle.
- Handshake:
  - A transfer happens on a clk edge where valid && ready.
  - Stage k advances when ready_k = !valid_k || ready_{k+1}, with ready_LEVELS = out_ready. Bubbles collapse.
  - in_ready = ready_0, combinational from the stage valids and out_ready.
  - While out_valid=1 && out_ready=0, out_data, out_valid and every stage holding data must stay stable.
  - No beat may be lost or duplicated.
  - in_data, in_amt and in_mode are sampled only on transfer; their value is a don't-care otherwise.
- Simultaneous input accept and output drain in the same cycle is legal; the pipeline stays full at 1 beat/cycle.
- Reset (asynchronous, active-high):
  - All stage valids clear to 0 immediately, so out_valid=0.
  - out_data and all stage data clear to 0.
  - in_ready reads 1 while rst is deasserted and the pipeline is empty.
  - Beats in flight at reset are discarded. A beat offered in the cycle rst deasserts may be accepted.
- in_amt=0 gives a result equal to in_data in every mode.
- No combinational path from in_data to out_data. The only comb paths are out_ready -> in_ready, through the ready chain.

Decomposition:
- Package shifter_pkg:
  - mode encodings MODE_SLL, MODE_SRL, MODE_SRA, MODE_ROL, MODE_ROR;
  - helper function for bit reversal.
- One sub-module: shift_level.
  - Parameters: WIDTH and level index K.
  - Contents: one 2^K conditional left shift with the mode-selected fill, plus its stage register and ready logic.
  - Instantiated LEVELS times with a generate loop.
- Top: entry/exit bit reversal plus handshake wiring.

Test Plan:
- WIDTH=8, out_ready=1, in_data=0x96, in_amt=3. Modes in turn give: SLL 0xB0, SRL 0x12, SRA 0xF2, ROL 0xB4, ROR 0xD2. Each result appears exactly 3 cycles after acceptance.
- in_amt=0 in all five modes, and mode=101 with in_amt=5, in_data=0x5A -> out_data=0x5A every time.
- Back-to-back stream of 16 random beats with out_ready held at 0 for 5 cycles mid-stream:
  - in_ready drops once all 3 stages hold data;
  - outputs stay stable while stalled;
  - all 16 results match the reference model in order, with no loss or duplication.
- Random out_ready (50%) and random in_valid over 1000 beats -> scoreboard matches, and throughput is 1 beat/cycle whenever out_ready=1 continuously.
- Assert rst asynchronously (between clock edges) with 2 beats in flight -> out_valid=0 and out_data=0 immediately, in_ready=1 after release, and no stale beat ever emerges.
- WIDTH=32 re-run: SRA on 0x80000001 by 31 -> 0xFFFFFFFF; ROR on 0x00000001 by 1 -> 0x80000000; latency 5 cycles.
